matvec_sequencer: RTL

Control block for the dot-product datapath of the RNN accelerator: it buffers one input vector, then sequences a full matrix-vector product by issuing weight-RAM column addresses and feeding aligned vector elements to the MAC array, one column per clock. It sits between the layer controller (vector source, start/done) and the dot-product engine with its weight RAM. It also handles accumulator clear, pipeline drain and completion signalling.

---
 rtl/matvec_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/matvec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matvec_sequencer
// Description : Control block for the RNN dot-product datapath. Buffers one
//               input vector of NCOL signed elements, then sequences a full
//               matrix-vector product: accumulator clear, NCOL column issues
//               (weight-RAM address one column ahead of the aligned vector
//               element), pipeline drain and a one-cycle done pulse.
//               Optional busy-cycle performance counter enabled by defining
//               MATVEC_SEQ_PERF_COUNT_EN (adds output perfCycles).
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_sequencer #(
    parameter int NCOL          = 16,
    parameter int BITWIDTH      = 18,
    parameter int ADDR_BITWIDTH = 4,
    parameter int MAC_LATENCY   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [BITWIDTH-1:0]      in_data,
    output logic                     in_ready,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_BITWIDTH-1:0] colAddress,
    output logic [BITWIDTH-1:0]      macInput,
    output logic                     macEnable,
    output logic                     macClear
`ifdef MATVEC_SEQ_PERF_COUNT_EN
    ,
    output logic [31:0]              perfCycles
`endif
);

    // State encoding
    localparam logic [2:0] c_ST_LOAD   = 3'd0;
    localparam logic [2:0] c_ST_READY  = 3'd1;
    localparam logic [2:0] c_ST_CLEAR  = 3'd2;
    localparam logic [2:0] c_ST_STREAM = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    localparam logic [ADDR_BITWIDTH-1:0] c_LAST_COL = ADDR_BITWIDTH'(NCOL - 1);
    localparam logic [ADDR_BITWIDTH-1:0] c_ADDR_ONE = ADDR_BITWIDTH'(1);

    // Drain counter only needs to reach MAC_LATENCY-1; keep at least one bit
    // so the declaration stays legal when MAC_LATENCY is 0 or 1.
    localparam int c_DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST =
        (MAC_LATENCY > 0) ? c_DRAIN_W'(MAC_LATENCY - 1) : '0;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE = c_DRAIN_W'(1);

    logic [2:0]               r_state;
    logic [2:0]               w_state_next;
    logic [ADDR_BITWIDTH-1:0] r_wr_idx;
    logic [ADDR_BITWIDTH-1:0] w_wr_idx_next;
    logic [ADDR_BITWIDTH-1:0] r_col;
    logic [ADDR_BITWIDTH-1:0] w_col_next;
    logic [c_DRAIN_W-1:0]     r_drain;
    logic [c_DRAIN_W-1:0]     w_drain_next;
    logic                     w_vec_we;
    logic [ADDR_BITWIDTH-1:0] w_vec_waddr;
    logic [BITWIDTH-1:0]      r_vec [NCOL];

    // State, write index, column and drain counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= c_ST_LOAD;
            r_wr_idx <= '0;
            r_col    <= '0;
            r_drain  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_wr_idx <= w_wr_idx_next;
            r_col    <= w_col_next;
            r_drain  <= w_drain_next;
        end
    end

    // Next-state, buffer write control and input handshake
    always_comb begin
        w_state_next  = r_state;
        w_wr_idx_next = r_wr_idx;
        w_col_next    = r_col;
        w_drain_next  = r_drain;
        w_vec_we      = 1'b0;
        w_vec_waddr   = r_wr_idx;
        in_ready      = 1'b0;
        case (r_state)
            c_ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_vec_we = 1'b1;
                    if (r_wr_idx == c_LAST_COL) begin
                        w_wr_idx_next = '0;
                        w_state_next  = c_ST_READY;
                    end else begin
                        w_wr_idx_next = r_wr_idx + c_ADDR_ONE;
                    end
                end
            end
            c_ST_READY: begin
                // A start in the same cycle wins; the element is refused.
                in_ready = !start;
                if (start) begin
                    w_state_next = c_ST_CLEAR;
                end else if (in_valid) begin
                    // New data restarts a full reload from element 0.
                    w_vec_we    = 1'b1;
                    w_vec_waddr = '0;
                    if (NCOL == 1) begin
                        w_wr_idx_next = '0;
                    end else begin
                        w_wr_idx_next = c_ADDR_ONE;
                        w_state_next  = c_ST_LOAD;
                    end
                end
            end
            c_ST_CLEAR: begin
                w_state_next = c_ST_STREAM;
                w_col_next   = '0;
            end
            c_ST_STREAM: begin
                if (r_col == c_LAST_COL) begin
                    w_col_next = '0;
                    if (MAC_LATENCY == 0) begin
                        w_state_next = c_ST_DONE;
                    end else begin
                        w_state_next = c_ST_DRAIN;
                        w_drain_next = '0;
                    end
                end else begin
                    w_col_next = r_col + c_ADDR_ONE;
                end
            end
            c_ST_DRAIN: begin
                if (r_drain == c_DRAIN_LAST) begin
                    w_state_next = c_ST_DONE;
                end else begin
                    w_drain_next = r_drain + c_DRAIN_ONE;
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_READY;
            end
            default: begin
                w_state_next = c_ST_LOAD;
            end
        endcase
    end

    // Vector buffer; contents are lost on reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCOL; i++) begin
                r_vec[i] <= '0;
            end
        end else if (w_vec_we) begin
            r_vec[w_vec_waddr] <= in_data;
        end
    end

    // Registered datapath strobes, decoded from the state being entered so
    // they line up with the state itself. The address runs one column ahead
    // of the element to cover the weight RAM's synchronous read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            colAddress <= '0;
            macInput   <= '0;
            macEnable  <= 1'b0;
            macClear   <= 1'b0;
        end else begin
            macClear  <= (w_state_next == c_ST_CLEAR);
            macEnable <= (w_state_next == c_ST_STREAM);
            if (w_state_next == c_ST_STREAM) begin
                macInput   <= r_vec[w_col_next];
                colAddress <= (w_col_next == c_LAST_COL) ? c_LAST_COL
                                                         : (w_col_next + c_ADDR_ONE);
            end else begin
                macInput   <= '0;
                colAddress <= '0;
            end
        end
    end

    assign busy = (r_state == c_ST_CLEAR)  || (r_state == c_ST_STREAM) ||
                  (r_state == c_ST_DRAIN)  || (r_state == c_ST_DONE);
    assign done = (r_state == c_ST_DONE);

`ifdef MATVEC_SEQ_PERF_COUNT_EN
    // Saturating count of busy cycles since reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perfCycles <= '0;
        end else if (busy && (perfCycles != '1)) begin
            perfCycles <= perfCycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
